// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the MIPS-lite controllers: sequencer states, opcode/funct
// values, datapath select encodings and the latched instruction class.
package multicycle_ctrl_pkg;

    localparam logic [4:0] JAL_REG = 5'd31;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] WRSEL_RT = 2'b00;
    localparam logic [1:0] WRSEL_RD = 2'b01;
    localparam logic [1:0] WRSEL_RA = 2'b10;

    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_DM  = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ADDU,
        CLS_SUBU,
        CLS_JR,
        CLS_ORI,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JAL
    } cls_e;

    function automatic logic cls_writes_rf(cls_e c);
        return (c == CLS_ADDU) || (c == CLS_SUBU) || (c == CLS_ORI) ||
               (c == CLS_LUI)  || (c == CLS_LW)   || (c == CLS_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational op/funct classifier; anything outside the supported set is
// reported as illegal and classed as NOP.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output cls_e       cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = CLS_NOP;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: cls_o     = CLS_ADDU;
                    FN_SUBU: cls_o     = CLS_SUBU;
                    FN_JR:   cls_o     = CLS_JR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ORI:  cls_o     = CLS_ORI;
            OP_LUI:  cls_o     = CLS_LUI;
            OP_LW:   cls_o     = CLS_LW;
            OP_SW:   cls_o     = CLS_SW;
            OP_BEQ:  cls_o     = CLS_BEQ;
            OP_JAL:  cls_o     = CLS_JAL;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS-lite datapath.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] WRsel,
    output logic [1:0] WDsel,
    output logic       EXTOp,
    output logic       Bsel,
    output logic [1:0] ALUOp,
    output logic       Br,
    output logic       LUIsel,
    output logic       Jal,
    output logic       Jr,
    output logic       illegal,
    output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    logic [2:0] state_q, state_d;
    cls_e       class_q;
    cls_e       dec_cls;
    logic       dec_illegal;

    multicycle_ctrl_decode ctrl_decode (
        .op_i      (op),
        .funct_i   (funct),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            class_q <= CLS_NOP;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                class_q <= dec_cls;
            end
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        WRsel    = WRSEL_RT;
        WDsel    = WDSEL_ALU;
        EXTOp    = 1'b0;
        Bsel     = 1'b0;
        ALUOp    = ALU_ADD;
        Br       = 1'b0;
        LUIsel   = 1'b0;
        Jal      = 1'b0;
        Jr       = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_cls == CLS_JAL) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                case (class_q)
                    CLS_ADDU: begin ALUOp = ALU_ADD; state_d = S_WB; end
                    CLS_SUBU: begin ALUOp = ALU_SUB; state_d = S_WB; end
                    CLS_ORI:  begin ALUOp = ALU_OR; Bsel = 1'b1; state_d = S_WB; end
                    CLS_LUI:  begin Bsel = 1'b1; state_d = S_WB; end
                    CLS_LW, CLS_SW: begin
                        Bsel    = 1'b1;
                        EXTOp   = 1'b1;
                        state_d = S_MEM;
                    end
                    CLS_BEQ: begin
                        ALUOp = ALU_SUB;
                        EXTOp = 1'b1;
                        Br    = 1'b1;
                        PCWr  = zero;
                    end
                    CLS_JR: begin
                        Jr   = 1'b1;
                        PCWr = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // DMWr is a level qualifier: it stays up for every wait cycle.
                if ((class_q == CLS_LW) || (class_q == CLS_SW)) begin
                    dmem_req = 1'b1;
                    DMWr     = (class_q == CLS_SW);
                    if (!dmem_ready) begin
                        state_d = S_MEM;
                    end else if (class_q == CLS_LW) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RFWr = cls_writes_rf(class_q);
                case (class_q)
                    CLS_ADDU, CLS_SUBU: WRsel = WRSEL_RD;
                    CLS_LUI: LUIsel = 1'b1;
                    CLS_LW:  WDsel = WDSEL_DM;
                    CLS_JAL: begin
                        WRsel = WRSEL_RA;
                        WDsel = WDSEL_PC4;
                        Jal   = 1'b1;
                        PCWr  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // Outputs stay quiet for as long as reset is held, including the FETCH request.
        if (reset) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            RFWr     = 1'b0;
            DMWr     = 1'b0;
            WRsel    = WRSEL_RT;
            WDsel    = WDSEL_ALU;
            EXTOp    = 1'b0;
            Bsel     = 1'b0;
            ALUOp    = ALU_ADD;
            Br       = 1'b0;
            LUIsel   = 1'b0;
            Jal      = 1'b0;
            Jr       = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // DECODE->FETCH only happens on an illegal instruction, so it is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if ((state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH)) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle's full control word is pushed
// to an expected queue when its inputs are driven and popped when sampled.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       PCWr, IRWr, imem_req, dmem_req, RFWr, DMWr;
    logic [1:0] WRsel, WDsel, ALUOp;
    logic       EXTOp, Bsel, Br, LUIsel, Jal, Jr, illegal;
    logic [2:0] state;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .RFWr       (RFWr),
        .DMWr       (DMWr),
        .WRsel      (WRsel),
        .WDsel      (WDsel),
        .EXTOp      (EXTOp),
        .Bsel       (Bsel),
        .ALUOp      (ALUOp),
        .Br         (Br),
        .LUIsel     (LUIsel),
        .Jal        (Jal),
        .Jr         (Jr),
        .illegal    (illegal),
        .state      (state)
    );

    // Control word layout:
    // [21:19] state [18] PCWr [17] IRWr [16] imem_req [15] dmem_req [14] RFWr [13] DMWr
    // [12:11] WRsel [10:9] WDsel [8] EXTOp [7] Bsel [6:5] ALUOp [4] Br [3] LUIsel [2] Jal [1] Jr [0] illegal
    localparam logic [21:0] M_PCWR = 22'h1 << 18;
    localparam logic [21:0] M_IRWR = 22'h1 << 17;
    localparam logic [21:0] M_IMEM = 22'h1 << 16;
    localparam logic [21:0] M_DMEM = 22'h1 << 15;
    localparam logic [21:0] M_RFWR = 22'h1 << 14;
    localparam logic [21:0] M_DMWR = 22'h1 << 13;
    localparam logic [21:0] M_EXT  = 22'h1 << 8;
    localparam logic [21:0] M_BSEL = 22'h1 << 7;
    localparam logic [21:0] M_BR   = 22'h1 << 4;
    localparam logic [21:0] M_LUI  = 22'h1 << 3;
    localparam logic [21:0] M_JAL  = 22'h1 << 2;
    localparam logic [21:0] M_JR   = 22'h1 << 1;
    localparam logic [21:0] M_ILL  = 22'h1;

    function automatic logic [21:0] st(input logic [2:0] s);
        return {s, 19'd0};
    endfunction
    function automatic logic [21:0] wr(input logic [1:0] v);
        return {9'd0, v, 11'd0};
    endfunction
    function automatic logic [21:0] wd(input logic [1:0] v);
        return {11'd0, v, 9'd0};
    endfunction
    function automatic logic [21:0] alu(input logic [1:0] v);
        return {15'd0, v, 5'd0};
    endfunction

    logic [21:0] obs;
    assign obs = {state, PCWr, IRWr, imem_req, dmem_req, RFWr, DMWr, WRsel, WDsel,
                  EXTOp, Bsel, ALUOp, Br, LUIsel, Jal, Jr, illegal};

    logic [21:0] exp_q[$];
    int checks;
    int failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare_now(input string tag);
        logic [21:0] expv;
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check, then move to the next falling edge.
    task automatic cyc(input string tag, input logic rst, input logic irdy,
                       input logic drdy, input logic zr, input logic [21:0] expv);
        reset      = rst;
        imem_ready = irdy;
        dmem_ready = drdy;
        zero       = zr;
        exp_q.push_back(expv);
        #1;
        compare_now(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    logic [21:0] f_done;
    logic [21:0] f_wait;

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        op         = 6'd0;
        funct      = 6'd0;
        zero       = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        f_done     = st(3'd0) | M_PCWR | M_IRWR | M_IMEM;
        f_wait     = st(3'd0) | M_IMEM;

        @(negedge clk);
        cyc("reset_hold", 1'b1, 1'b1, 1'b1, 1'b0, 22'd0);
        cyc("reset_hold2", 1'b1, 1'b1, 1'b1, 1'b0, 22'd0);
        cyc("fetch_wait", 1'b0, 1'b0, 1'b0, 1'b0, f_wait);
        cyc("fetch_wait2", 1'b0, 1'b0, 1'b0, 1'b0, f_wait);

        set_instr(6'b000000, 6'b100001);
        cyc("addu_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("addu_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("addu_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | alu(2'b00));
        cyc("addu_w", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd4) | M_RFWR | wr(2'b01) | wd(2'b00));

        set_instr(6'b000000, 6'b100011);
        cyc("subu_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("subu_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("subu_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | alu(2'b01));
        cyc("subu_w", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd4) | M_RFWR | wr(2'b01));

        set_instr(6'b001101, 6'b000000);
        cyc("ori_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("ori_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("ori_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | M_BSEL | alu(2'b10));
        cyc("ori_w", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd4) | M_RFWR | wr(2'b00));

        set_instr(6'b001111, 6'b000000);
        cyc("lui_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("lui_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("lui_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | M_BSEL);
        cyc("lui_w", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd4) | M_RFWR | M_LUI);

        set_instr(6'b000011, 6'b010101);
        cyc("jal_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("jal_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("jal_w", 1'b0, 1'b1, 1'b1, 1'b0,
            st(3'd4) | M_RFWR | wr(2'b10) | wd(2'b10) | M_JAL | M_PCWR);

        set_instr(6'b100011, 6'b000000);
        cyc("lw_f", 1'b0, 1'b1, 1'b0, 1'b0, f_done);
        cyc("lw_d", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd1));
        cyc("lw_e", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd2) | M_BSEL | M_EXT);
        for (int i = 0; i < 3; i++) begin
            cyc("lw_m_wait", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd3) | M_DMEM);
        end
        cyc("lw_m_done", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd3) | M_DMEM);
        cyc("lw_w", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd4) | M_RFWR | wd(2'b01));

        set_instr(6'b000100, 6'b000000);
        cyc("beq0_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("beq0_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("beq0_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | M_BR | M_EXT | alu(2'b01));
        cyc("beq1_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("beq1_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("beq1_e", 1'b0, 1'b1, 1'b1, 1'b1, st(3'd2) | M_BR | M_EXT | alu(2'b01) | M_PCWR);

        set_instr(6'b000000, 6'b001000);
        cyc("jr_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("jr_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1));
        cyc("jr_e", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd2) | M_JR | M_PCWR);

        set_instr(6'b111111, 6'b000000);
        cyc("ill_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("ill_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1) | M_ILL);
        cyc("ill_next_fetch", 1'b0, 1'b0, 1'b1, 1'b0, f_wait);

        set_instr(6'b000000, 6'b111110);
        cyc("illfn_f", 1'b0, 1'b1, 1'b1, 1'b0, f_done);
        cyc("illfn_d", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd1) | M_ILL);

        set_instr(6'b101011, 6'b000000);
        cyc("sw_f", 1'b0, 1'b1, 1'b0, 1'b0, f_done);
        cyc("sw_d", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd1));
        cyc("sw_e", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd2) | M_BSEL | M_EXT);
        cyc("sw_m_wait", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd3) | M_DMEM | M_DMWR);
        // Assert reset in the middle of a held MEM cycle, away from any clock edge.
        exp_q.push_back(st(3'd3) | M_DMEM | M_DMWR);
        #1;
        compare_now("sw_m_before_rst");
        #1;
        reset = 1'b1;
        exp_q.push_back(22'd0);
        #1;
        compare_now("sw_async_rst");
        @(posedge clk);
        @(negedge clk);
        cyc("sw_rst_held", 1'b1, 1'b1, 1'b0, 1'b0, 22'd0);
        cyc("post_rst_fetch_wait", 1'b0, 1'b0, 1'b0, 1'b0, f_wait);
        cyc("sw2_f", 1'b0, 1'b1, 1'b0, 1'b0, f_done);
        cyc("sw2_d", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd1));
        cyc("sw2_e", 1'b0, 1'b1, 1'b0, 1'b0, st(3'd2) | M_BSEL | M_EXT);
        cyc("sw2_m_done", 1'b0, 1'b1, 1'b1, 1'b0, st(3'd3) | M_DMEM | M_DMWR);
        cyc("sw2_next_fetch", 1'b0, 1'b0, 1'b1, 1'b0, f_wait);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
